// File: rtl/nxn_game_controller.sv
// N x N, K-in-a-row two-player board controller with cursor, placement and win/draw detection.
// Latency: button press -> cursor update 1 cycle; legal place -> WIN/DRAW/next turn 5 cycles.
// Backpressure: one action per button press; RELEASE waits for all buttons low, CHECK ignores buttons.
// Ports: clk/rst_n; start; up/down/left/right/place buttons; cursor, player, board bitmaps,
//        move_count, winner, illegal pulse and one-hot state flags out.
module nxn_game_controller #(
    parameter int N            = 3,
    parameter int K            = 3,
    parameter int FIRST_PLAYER = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           up,
    input  logic                           down,
    input  logic                           left,
    input  logic                           right,
    input  logic                           place,
    output logic [$clog2(N)-1:0]           cur_row,
    output logic [$clog2(N)-1:0]           cur_col,
    output logic                           player,
    output logic [N*N-1:0]                 p1_cells,
    output logic [N*N-1:0]                 p2_cells,
    output logic [$clog2(N*N+1)-1:0]       move_count,
    output logic [1:0]                     winner,
    output logic                           illegal,
    output logic                           q_Idle,
    output logic                           q_Turn,
    output logic                           q_Release,
    output logic                           q_Check,
    output logic                           q_Win,
    output logic                           q_Draw
);

    localparam int CW = $clog2(N);
    localparam int NN = N * N;
    localparam int MW = $clog2(N * N + 1);

    localparam logic [CW-1:0] MID      = CW'(N / 2);
    localparam logic [CW-1:0] LAST     = CW'(N - 1);
    localparam logic [MW-1:0] FULL     = MW'(NN);
    localparam logic          FP       = (FIRST_PLAYER != 0);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TURN    = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_WIN     = 3'd4;
    localparam logic [2:0] S_DRAW    = 3'd5;

    logic [2:0]    state;
    logic [1:0]    dir;
    logic          win_flag;
    logic [CW-1:0] last_row;
    logic [CW-1:0] last_col;

    logic          any_btn;
    logic [NN-1:0] cur_mask;
    logic          occupied;
    logic [NN-1:0] own_cells;
    int            run_len;
    logic          win_hit;

    assign any_btn  = up | down | left | right | place;
    assign cur_mask = NN'(1) << (int'(cur_row) * N + int'(cur_col));
    assign occupied = |((p1_cells | p2_cells) & cur_mask);

    // The player who just placed still owns the turn during CHECK,
    // so the run is measured over that player's bitmap.
    assign own_cells = player ? p2_cells : p1_cells;

    // Run length through the last placed cell along the current direction:
    // walk up to K-1 steps each way, stopping at the edge or the first
    // cell not owned by the mover.
    always_comb begin : run_calc
        int   dr;
        int   dc;
        int   r;
        int   c;
        int   idx;
        logic go;
        logic inb;
        logic [NN-1:0] sh;
        dr  = 0;
        dc  = 1;
        r   = 0;
        c   = 0;
        idx = 0;
        go  = 1'b0;
        inb = 1'b0;
        sh  = '0;
        run_len = 1;
        case (dir)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        for (int side = 0; side < 2; side++) begin
            go = 1'b1;
            for (int s = 1; s < K; s++) begin
                if (side == 0) begin
                    r = int'(last_row) + s * dr;
                    c = int'(last_col) + s * dc;
                end else begin
                    r = int'(last_row) - s * dr;
                    c = int'(last_col) - s * dc;
                end
                inb = (r >= 0) && (r < N) && (c >= 0) && (c < N);
                idx = inb ? (r * N + c) : 0;
                sh  = own_cells >> idx;
                if (go && inb && sh[0]) begin
                    run_len = run_len + 1;
                end else begin
                    go = 1'b0;
                end
            end
        end
    end

    assign win_hit = (run_len >= K);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dir        <= 2'd0;
            win_flag   <= 1'b0;
            last_row   <= '0;
            last_col   <= '0;
            cur_row    <= MID;
            cur_col    <= MID;
            player     <= FP;
            p1_cells   <= '0;
            p2_cells   <= '0;
            move_count <= '0;
            winner     <= 2'b00;
            illegal    <= 1'b0;
        end else begin
            illegal <= 1'b0;
            if (start) begin
                p1_cells   <= '0;
                p2_cells   <= '0;
                move_count <= '0;
                winner     <= 2'b00;
                cur_row    <= MID;
                cur_col    <= MID;
                player     <= FP;
                dir        <= 2'd0;
                win_flag   <= 1'b0;
                // A button still held from the start press must be released
                // before it can act.
                state      <= any_btn ? S_RELEASE : S_TURN;
            end else begin
                case (state)
                    S_TURN: begin
                        if (place) begin
                            if (occupied) begin
                                illegal <= 1'b1;
                                state   <= S_RELEASE;
                            end else begin
                                if (player) p2_cells <= p2_cells | cur_mask;
                                else        p1_cells <= p1_cells | cur_mask;
                                move_count <= move_count + MW'(1);
                                last_row   <= cur_row;
                                last_col   <= cur_col;
                                dir        <= 2'd0;
                                win_flag   <= 1'b0;
                                state      <= S_CHECK;
                            end
                        end else if (right) begin
                            cur_col <= (cur_col == LAST) ? '0 : cur_col + CW'(1);
                            state   <= S_RELEASE;
                        end else if (left) begin
                            cur_col <= (cur_col == '0) ? LAST : cur_col - CW'(1);
                            state   <= S_RELEASE;
                        end else if (down) begin
                            cur_row <= (cur_row == LAST) ? '0 : cur_row + CW'(1);
                            state   <= S_RELEASE;
                        end else if (up) begin
                            cur_row <= (cur_row == '0) ? LAST : cur_row - CW'(1);
                            state   <= S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        if (!any_btn) state <= S_TURN;
                    end
                    S_CHECK: begin
                        if (dir == 2'd3) begin
                            // Fold this cycle's result in directly; the
                            // registered flag only covers dirs 0..2.
                            if (win_flag || win_hit) begin
                                winner <= player ? 2'b10 : 2'b01;
                                state  <= S_WIN;
                            end else if (move_count == FULL) begin
                                state  <= S_DRAW;
                            end else begin
                                player <= ~player;
                                state  <= any_btn ? S_RELEASE : S_TURN;
                            end
                        end else begin
                            if (win_hit) win_flag <= 1'b1;
                            dir <= dir + 2'd1;
                        end
                    end
                    default: begin
                        // IDLE, WIN and DRAW hold until start or reset.
                        state <= state;
                    end
                endcase
            end
        end
    end

    assign q_Idle    = (state == S_IDLE);
    assign q_Turn    = (state == S_TURN);
    assign q_Release = (state == S_RELEASE);
    assign q_Check   = (state == S_CHECK);
    assign q_Win     = (state == S_WIN);
    assign q_Draw    = (state == S_DRAW);

endmodule

// File: tb/tb_nxn_game_controller.sv
module tb_nxn_game_controller;

    logic clk;
    logic rst_n;
    logic start, up, down, left, right, place;

    // 3x3, K=3 instance
    logic [1:0]  a_row, a_col;
    logic        a_player;
    logic [8:0]  a_p1, a_p2;
    logic [3:0]  a_mc;
    logic [1:0]  a_win;
    logic        a_ill, a_qi, a_qt, a_qr, a_qc, a_qw, a_qd;

    // 5x5, K=4 instance
    logic [2:0]  b_row, b_col;
    logic        b_player;
    logic [24:0] b_p1, b_p2;
    logic [4:0]  b_mc;
    logic [1:0]  b_win;
    logic        b_ill, b_qi, b_qt, b_qr, b_qc, b_qw, b_qd;

    int n_cmp = 0;
    int n_bad = 0;
    int tb_r, tb_c;

    nxn_game_controller #(.N(3), .K(3), .FIRST_PLAYER(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .up(up), .down(down), .left(left), .right(right), .place(place),
        .cur_row(a_row), .cur_col(a_col), .player(a_player),
        .p1_cells(a_p1), .p2_cells(a_p2), .move_count(a_mc),
        .winner(a_win), .illegal(a_ill),
        .q_Idle(a_qi), .q_Turn(a_qt), .q_Release(a_qr),
        .q_Check(a_qc), .q_Win(a_qw), .q_Draw(a_qd)
    );

    nxn_game_controller #(.N(5), .K(4), .FIRST_PLAYER(0)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .up(up), .down(down), .left(left), .right(right), .place(place),
        .cur_row(b_row), .cur_col(b_col), .player(b_player),
        .p1_cells(b_p1), .p2_cells(b_p2), .move_count(b_mc),
        .winner(b_win), .illegal(b_ill),
        .q_Idle(b_qi), .q_Turn(b_qt), .q_Release(b_qr),
        .q_Check(b_qc), .q_Win(b_qw), .q_Draw(b_qd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        tb_r = n / 2;
        tb_c = n / 2;
    endtask

    task automatic press_down(input int n);
        down = 1'b1; tick(); down = 1'b0; tick();
        tb_r = (tb_r + 1) % n;
    endtask

    task automatic press_right(input int n);
        right = 1'b1; tick(); right = 1'b0; tick();
        tb_c = (tb_c + 1) % n;
    endtask

    task automatic move_to(input int n, input int r, input int c);
        for (int i = 0; i < 2 * n && tb_r != r; i++) press_down(n);
        for (int i = 0; i < 2 * n && tb_c != c; i++) press_right(n);
    endtask

    // Full legal placement: one place cycle plus four CHECK cycles.
    task automatic place_at(input int n, input int r, input int c);
        move_to(n, r, c);
        place = 1'b1; tick(); place = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        {start, up, down, left, right, place} = '0;
        tb_r = 1; tb_c = 1;
        #23;
        // Reset values
        check("rst_idle", a_qi, 1);
        check("rst_row", a_row, 1);
        check("rst_col", a_col, 1);
        check("rst_player", a_player, 0);
        check("rst_boards", {a_p1, a_p2}, 0);
        check("rst_mc", a_mc, 0);
        check("rst_winner", a_win, 0);
        check("rst_b_cursor", {b_row, b_col}, {3'd2, 3'd2});
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("idle_hold", a_qi, 1);

        // 1. Cursor wrap and no auto-repeat
        do_start(3);
        check("t1_turn", a_qt, 1);
        right = 1'b1; tick();
        check("t1_col2", a_col, 2);
        right = 1'b0; tick();
        right = 1'b1; tick();
        check("t1_wrap_col0", a_col, 0);
        right = 1'b0; tick();
        right = 1'b1; repeat (50) tick();
        check("t1_hold_once", a_col, 1);
        check("t1_hold_release", a_qr, 1);
        right = 1'b0; tick();
        check("t1_back_turn", a_qt, 1);
        left = 1'b1; tick(); left = 1'b0; tick();
        check("t1_left", a_col, 0);
        up = 1'b1; tick(); up = 1'b0; tick();
        check("t1_up", a_row, 0);
        up = 1'b1; tick(); up = 1'b0; tick();
        check("t1_up_wrap", a_row, 2);

        // 2. P1 wins on the top row
        do_start(3);
        place_at(3, 0, 0);
        check("t2_toggle", a_player, 1);
        place_at(3, 1, 0);
        place_at(3, 0, 1);
        place_at(3, 1, 1);
        move_to(3, 0, 2);
        place = 1'b1; tick(); place = 1'b0;
        repeat (3) tick();
        check("t2_still_check", a_qc, 1);
        tick();
        check("t2_win", a_qw, 1);
        check("t2_winner", a_win, 2'b01);
        check("t2_mc", a_mc, 5);
        check("t2_p1", a_p1, 9'h007);
        check("t2_p2", a_p2, 9'h018);
        check("t2_player_kept", a_player, 0);
        right = 1'b1; tick(); right = 1'b0; tick();
        check("t2_frozen_col", a_col, 2);
        check("t2_frozen_win", a_qw, 1);

        // 3. Occupied cell rejection
        do_start(3);
        place_at(3, 1, 1);
        place = 1'b1; tick();
        check("t3_illegal", a_ill, 1);
        check("t3_player", a_player, 1);
        check("t3_p1", a_p1, 9'h010);
        check("t3_p2", a_p2, 9'h000);
        check("t3_release", a_qr, 1);
        place = 1'b0; tick();
        check("t3_pulse_end", a_ill, 0);
        check("t3_mc", a_mc, 1);

        // 4. Draw
        do_start(3);
        place_at(3, 0, 0);
        place_at(3, 0, 1);
        place_at(3, 0, 2);
        place_at(3, 1, 1);
        place_at(3, 1, 0);
        place_at(3, 1, 2);
        place_at(3, 2, 1);
        place_at(3, 2, 0);
        place_at(3, 2, 2);
        check("t4_draw", a_qd, 1);
        check("t4_mc", a_mc, 9);
        check("t4_winner", a_win, 0);
        check("t4_p1", a_p1, 9'h18D);
        check("t4_p2", a_p2, 9'h072);

        // 5. 5x5, K=4: P2 anti-diagonal; P1 3-run on bottom edge
        do_start(5);
        place_at(5, 4, 0);
        place_at(5, 0, 4);
        place_at(5, 4, 1);
        place_at(5, 1, 3);
        place_at(5, 4, 2);
        check("t5_edge3_nowin", b_qt, 1);
        check("t5_edge3_winner", b_win, 0);
        place_at(5, 2, 2);
        place_at(5, 0, 0);
        place_at(5, 3, 1);
        check("t5_win", b_qw, 1);
        check("t5_winner", b_win, 2'b10);
        check("t5_mc", b_mc, 8);

        // 6. Reset mid-CHECK, then start beats place
        do_start(3);
        place = 1'b1; tick(); place = 1'b0; tick();
        check("t6_in_check", a_qc, 1);
        rst_n = 1'b0;
        #2;
        check("t6_rst_idle", a_qi, 1);
        check("t6_rst_boards", {a_p1, a_p2}, 0);
        check("t6_rst_mc", a_mc, 0);
        check("t6_rst_cursor", {a_row, a_col}, 4'b0101);
        check("t6_rst_player", a_player, 0);
        check("t6_rst_ill", a_ill, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        do_start(3);
        place_at(3, 1, 1);
        check("t6_placed", a_p1, 9'h010);
        check("t6_p2_turn", a_player, 1);
        start = 1'b1; place = 1'b1; tick();
        check("t6_start_p1", a_p1, 0);
        check("t6_start_p2", a_p2, 0);
        check("t6_start_mc", a_mc, 0);
        check("t6_start_player", a_player, 0);
        check("t6_start_release", a_qr, 1);
        start = 1'b0; place = 1'b0; tick();
        check("t6_turn", a_qt, 1);
        check("t6_still_clear", a_p1 | a_p2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
